// File: rtl/clock_pkg.sv
// Shared constants for the clock front panel: key count, clock rate and key roles.
// Also provides the counter-width helper used by the key front-end.
package clock_pkg;

  localparam int unsigned NKEY     = 5;
  localparam int unsigned CLK_HZ   = 50_000_000;

  localparam int unsigned KEY_SET  = 0;
  localparam int unsigned KEY_SEL  = 1;
  localparam int unsigned KEY_MODE = 4;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key channel: 2-FF synchroniser, debounce window counter, debounced level
// and a one-cycle press pulse. The press pulse is also offered one cycle early.
module key_debounce #(
  parameter int unsigned DB_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pin_n,
  output logic o_press,
  output logic o_lvl,
  output logic o_press_nxt
);
  import clock_pkg::*;

  localparam int unsigned   CW   = cnt_width(DB_CYC);
  localparam logic [CW-1:0] LAST = CW'(DB_CYC - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_lvl;
  logic          r_press;
  logic          w_diff;
  logic          w_commit;

  assign w_diff      = r_sync2 ^ r_lvl;
  assign w_commit    = w_diff && (r_cnt == LAST);
  // Only a 0->1 commit is a press; releases toggle the level silently.
  assign o_press_nxt = w_commit && !r_lvl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      r_lvl   <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= ~i_pin_n;
      r_sync2 <= r_sync1;
      r_press <= o_press_nxt;
      if (w_commit) begin
        r_lvl <= ~r_lvl;
        r_cnt <= '0;
      end else if (w_diff) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_press;
  assign o_lvl   = r_lvl;

endmodule

// File: rtl/key_scan.sv
// Push-button front-end: NKEY debounced channels with press pulses, plus an
// inactivity timer that pulses flag_10s once per idle period.
module key_scan #(
  parameter int unsigned NKEY     = clock_pkg::NKEY,
  parameter int unsigned DB_CYC   = 1_000_000,
  parameter int unsigned IDLE_CYC = 500_000_000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NKEY-1:0] key_n,
  output logic [NKEY-1:0] key,
  output logic [NKEY-1:0] key_lvl,
  output logic            flag_10s
);
  import clock_pkg::*;

  localparam int unsigned   IW        = cnt_width(IDLE_CYC);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYC - 1);

  logic [NKEY-1:0] w_press_nxt;
  logic [IW-1:0]   r_idle_cnt;
  logic            r_armed;
  logic            r_flag;

  for (genvar g = 0; g < NKEY; g++) begin : g_key
    key_debounce #(.DB_CYC(DB_CYC)) u_db (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_pin_n     (key_n[g]),
      .o_press     (key[g]),
      .o_lvl       (key_lvl[g]),
      .o_press_nxt (w_press_nxt[g])
    );
  end

  // The timer restarts on the same edge that raises a key pulse, so the flag
  // lands exactly IDLE_CYC edges after the pulse and a press beats the terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle_cnt <= '0;
      r_armed    <= 1'b1;
      r_flag     <= 1'b0;
    end else begin
      r_flag <= 1'b0;
      if (|w_press_nxt) begin
        r_idle_cnt <= '0;
        r_armed    <= 1'b1;
      end else if (r_armed) begin
        if (r_idle_cnt == IDLE_LAST) begin
          r_flag  <= 1'b1;
          r_armed <= 1'b0;
        end else begin
          r_idle_cnt <= r_idle_cnt + 1'b1;
        end
      end
    end
  end

  assign flag_10s = r_flag;

endmodule

// File: doc/key_scan.md
# key_scan

Front-end for the clock's push-buttons. It synchronises and debounces five raw active-low key inputs and emits one-clock press pulses on `key[4:0]`. It also raises a one-clock `flag_10s` after a long period with no key press. It sits between the board pins and `mode_sel`, which consumes `key` and `flag_10s` directly.

## Interface
Parameters:
- `NKEY`, 5: number of key channels.
- `DB_CYC`, 1_000_000: debounce window in clk cycles (20 ms @ 50 MHz); legal range ≥ 2.
- `IDLE_CYC`, 500_000_000: inactivity timeout in clk cycles (10 s @ 50 MHz); legal range ≥ 2.

Ports:
- `clk`, input, 1: system clock, 50 MHz.
- `rst_n`, input, 1: reset; asynchronous, active-low.
- `key_n`, input, NKEY: raw button pins, 0 = pressed, asynchronous to clk.
- `key`, output, NKEY: one-cycle press pulse per channel; bit 0 = set, bit 1 = digit select, bit 4 = mode.
- `key_lvl`, output, NKEY: debounced level, 1 = held.
- `flag_10s`, output, 1: one-cycle pulse when IDLE_CYC cycles elapse with no press pulse.

## Operation
Per channel (independent; any number of channels may act in the same cycle):
- Synchroniser: the raw pin passes through a 2-FF synchroniser, giving `s[i]`. `s[i]` is the inverted pin, so 1 = pressed.
- Debounce counter: `cnt[i]`, width $clog2(DB_CYC).
  - While `s[i] != key_lvl[i]`: `cnt[i]` increments.
  - While `s[i] == key_lvl[i]`: `cnt[i]` clears to 0.
  - A single-cycle glitch therefore restarts the window.
- Commit: when `s[i] != key_lvl[i]` and `cnt[i] == DB_CYC-1`, the next edge does three things:
  - `key_lvl[i]` toggles.
  - `cnt[i]` clears.
  - If the new level is 1, `key[i]` is 1 for exactly that one cycle.
- Release produces no pulse.
- A held key produces one pulse only; there is no auto-repeat.

Idle timer (`idle_cnt`, width $clog2(IDLE_CYC), plus an `armed` bit):
- Any cycle with `|key` = 1: `idle_cnt` clears to 0 and `armed` sets to 1.
- Otherwise, while `armed` and `idle_cnt < IDLE_CYC-1`: `idle_cnt` increments.
- When `armed` and `idle_cnt == IDLE_CYC-1` with no press this cycle, the next edge does three things:
  - `flag_10s` = 1 for one cycle.
  - `armed` clears.
  - `idle_cnt` holds.
- `flag_10s` fires once per idle period. It is not re-issued until a new press re-arms the timer.
- A press in the same cycle as the terminal count wins: the counter clears and no flag is raised.
- A held key (`key_lvl` = 1) does not block the timer; only pulses count as activity.

Reset (asynchronous, also mid-operation):
- Synchroniser flops reset to 0 (released).
- `cnt`, `key_lvl`, `key`, `flag_10s` and `idle_cnt` reset to 0.
- `armed` resets to 1, so `flag_10s` fires IDLE_CYC cycles after reset if no key is pressed.
- A key already held during reset release is debounced as a fresh press and yields one pulse after the normal latency.

## Timing
- Press latency: a pin held low from the edge where it is first sampled gives a `key[i]` pulse exactly 2 + DB_CYC edges later. This is 2 synchroniser stages plus a DB_CYC-cycle stable window.
- A bounce shorter than DB_CYC cycles gives no pulse and no `key_lvl` change.
- Release latency on `key_lvl` is the same: 2 + DB_CYC cycles.
- Idle: `flag_10s` asserts IDLE_CYC cycles after the cycle in which the last `key` pulse was high.
- All outputs are registered; there is no combinational path from `key_n` to any output.

## Structure
- Shared package `clock_pkg` holds:
  - `NKEY` = 5 and `CLK_HZ` = 50_000_000.
  - Key index constants `KEY_SET` = 0, `KEY_SEL` = 1, `KEY_MODE` = 4, used by `mode_sel` and downstream blocks.
- Sub-module `key_debounce` covers one channel: synchroniser, counter, level and pulse. It is generate-instantiated NKEY times.
- The idle timer stays in `key_scan`.

## Test plan
Run with DB_CYC = 8, IDLE_CYC = 100.
- Clean press: `key_n[0]` low at cycle 10, held for 50 cycles -> `key[0]` = 1 only at cycle 20; `key_lvl[0]` rises at 20 and falls at 70; no further `key` pulse.
- Bounce: `key_n[1]` toggles low/high every 3 cycles for 30 cycles, then settles low -> exactly one `key[1]` pulse, 10 cycles after settling; no pulse during the bounce.
- Simultaneous: `key_n[0]` and `key_n[4]` low in the same cycle -> `key[0]` and `key[4]` pulse in the same cycle; other bits stay 0.
- Idle: after reset with no presses -> `flag_10s` pulses once at cycle 100 and never again. After a `key[1]` pulse at cycle T -> `flag_10s` at T + 100 only.
- Press at terminal count: `key[2]` pulse timed to the cycle with `idle_cnt` = 99 -> no `flag_10s`; the next flag comes 100 cycles later.
- Reset mid-debounce: assert `rst_n` low at `cnt[3]` = 5 while `key_n[3]` is held low -> all outputs 0 during reset; after release, `key[3]` pulses exactly 10 cycles later.
